// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   state_t        : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : default operand/result width in bits
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
// Single-bit gate-level full adder, kept generic so multi-bit adders can
// instantiate it unchanged.
// Ports:
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   c         : carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic c
);

    logic p;

    assign p   = a ^ b;
    assign sum = p ^ cin;
    assign c   = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder/subtractor. One bit per clock, LSB first, through a single
// full-adder cell. An operation takes exactly WIDTH edges from the accepting
// edge to the done pulse.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request a new operation (sampled in IDLE or DONE only)
//   a, b     : operands, captured at the accepting edge
//   cin      : carry-in for add mode (ignored when subtracting)
//   sub      : 0 = a + b + cin, 1 = a - b
//   busy     : high while the operation runs
//   done     : one-cycle pulse, results valid
//   sum      : result, held until the next accepted start
//   cout     : carry-out (add) / not-borrow (subtract)
//   overflow : two's-complement signed overflow
// Handshake: start is a request that is only looked at when busy is low;
// acceptance is visible as busy rising the following cycle. done marks the
// single cycle where results are first valid; they stay valid afterwards.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_c;
    logic             last_bit;

    fa_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .sum (fa_sum),
        .c   (fa_c)
    );

    // cnt counts bits already processed; the MSB is handled when cnt == WIDTH-1.
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        // Subtraction is a + ~b + 1: complement b, seed carry with 1.
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    if (last_bit) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cout     <= fa_c;
                        // carry register still holds the carry into the MSB here.
                        overflow <= fa_c ^ carry;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8): table of directed vectors
// plus hand-written sequences for start-during-run, reset mid-run and
// back-to-back operation with start held through DONE.
module tb_serial_adder;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [W+1:0] exp_q[$];  // {cout, overflow, sum}

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " sum"}, 64'(sum), 64'(e[W-1:0]));
            check({tag, " cout"}, 64'(cout), 64'(e[W+1]));
            check({tag, " overflow"}, 64'(overflow), 64'(e[W]));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vc, input logic vs,
                            input logic [W-1:0] es, input logic eco, input logic eov);
        @(negedge clk);
        a     = va;
        b     = vb;
        cin   = vc;
        sub   = vs;
        start = 1'b1;
        exp_q.push_back({eco, eov, es});
    endtask

    // Counts edges after the accepting edge until done is seen.
    // inject_at > 0 pulses start with junk operands after that edge.
    task automatic wait_done(input int inject_at, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                return;
            end
            if (!busy) busy_ok = 1'b0;
            if (inject_at > 0 && e == inject_at) begin
                @(negedge clk);
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
                cin   = 1'b1;
                sub   = ~sub;
            end else if (inject_at > 0 && e == inject_at + 1) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    // ---------------- test ----------------
    int  lat;
    bit  busy_ok;
    logic [W-1:0] held;

    initial begin
        vecs[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};  // cin ignored
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        // Reset is asynchronous: outputs are cleared before any clock edge.
        #2;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset sum", 64'(sum), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 7; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                     vecs[i].s, vecs[i].co, vecs[i].ov);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d accepted busy", i), 64'(busy), 64'd1);
            @(negedge clk);
            start = 1'b0;
            // Disturb inputs after acceptance; the operation must not notice.
            a   = W'($urandom_range(0, 255));
            b   = W'($urandom_range(0, 255));
            cin = ~cin;
            sub = ~sub;
            wait_done(0, lat, busy_ok);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd8);
            check($sformatf("vec%0d busy in run", i), 64'(busy_ok), 64'd1);
            check($sformatf("vec%0d busy at done", i), 64'(busy), 64'd0);
            check_result($sformatf("vec%0d", i));
            held = sum;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
            check($sformatf("vec%0d sum held", i), 64'(sum), 64'(held));
            check($sformatf("vec%0d busy idle", i), 64'(busy), 64'd0);
        end

        // ---- start during RUN is ignored ----
        drive_op(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat, busy_ok);
        check("ignore latency", 64'(lat), 64'd8);
        check("ignore busy", 64'(busy_ok), 64'd1);
        check_result("ignore");
        @(posedge clk);
        #1;
        check("ignore no restart", 64'(busy), 64'd0);

        // ---- reset between E4 and E5 ----
        drive_op(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst sum", 64'(sum), 64'd0);
        check("midrst cout", 64'(cout), 64'd0);
        check("midrst overflow", 64'(overflow), 64'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int e = 0; e < 12; e++) begin
                @(posedge clk);
                #1;
                if (done || busy) saw_done = 1'b1;
            end
            check("midrst no done", 64'(saw_done), 64'd0);
        end

        // ---- start held through DONE: back-to-back ----
        drive_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("b2b first accept", 64'(busy), 64'd1);
        @(negedge clk);
        // start stays high; second operands presented now.
        a   = 8'h3C;
        b   = 8'h05;
        cin = 1'b0;
        sub = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'h41});
        wait_done(0, lat, busy_ok);
        check("b2b first latency", 64'(lat), 64'd8);
        check_result("b2b first");
        @(posedge clk);
        #1;
        check("b2b second accept busy", 64'(busy), 64'd1);
        check("b2b second accept done", 64'(done), 64'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(0, lat, busy_ok);
        check("b2b second latency", 64'(lat), 64'd8);
        check("b2b second busy", 64'(busy_ok), 64'd1);
        check_result("b2b second");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
